// File: rtl/spi_slave_byte.sv
// -----------------------------------------------------------------------------
// spi_slave_byte
//
// SPI target (responder) that oversamples SCK/CSN/MOSI on the system clock and
// shifts DATA_WIDTH-bit words MSB-first in both directions. Transmit data comes
// from a one-entry holding buffer (valid/ready); received words are presented
// on a registered rx_data with a one-cycle rx_valid strobe.
//
// Ports:
//   clk          system clock, at least 8x the SCK frequency
//   rstn         asynchronous active-low reset
//   spi_sck_i    SCK from the external master
//   spi_csn_i    chip select, active low
//   spi_sdi_i    MOSI
//   spi_sdo_o    MISO data (MSB of the transmit shift register)
//   spi_sdo_en   MISO tri-state control, 1 = high-Z, 0 = drive spi_sdo_o
//   tx_data      next word to send
//   tx_valid     tx_data valid
//   tx_ready     holding buffer empty
//   rx_data      last complete received word, held until the next completes
//   rx_valid     one-cycle strobe when rx_data updates
//   tx_underrun  one-cycle strobe when FILL is loaded instead of real data
//   busy         frame active (synchronized CSN low)
// -----------------------------------------------------------------------------
module spi_slave_byte #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter bit                    CPOL        = 1'b0,
    parameter bit                    CPHA        = 1'b0,
    parameter logic [DATA_WIDTH-1:0] FILL        = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  spi_sck_i,
    input  logic                  spi_csn_i,
    input  logic                  spi_sdi_i,
    output logic                  spi_sdo_o,
    output logic                  spi_sdo_en,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, sdi_sync, flush_sync;
    logic                   sck_s, csn_s, sdi_s, sync_ok;
    logic                   sck_p1, csn_p1;
    logic                   armed;

    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   frame_end, load_en, shift_en, sample_en;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  tx_shift, rx_shift, buf_data;
    logic                   buf_full;
    logic                   accept;

    // ---- synchronizers -------------------------------------------------------
    // flush_sync marks when the chains hold real pin values rather than their
    // reset values, so a CSN held low through reset cannot look like "high".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync   <= {SYNC_STAGES{CPOL}};
            csn_sync   <= {SYNC_STAGES{1'b1}};
            sdi_sync   <= '0;
            flush_sync <= '0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            csn_sync   <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
            sdi_sync   <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
            flush_sync <= {flush_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign csn_s   = csn_sync[SYNC_STAGES-1];
    assign sdi_s   = sdi_sync[SYNC_STAGES-1];
    assign sync_ok = flush_sync[SYNC_STAGES-1];

    // ---- edge detect / arming --------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_p1 <= CPOL;
            csn_p1 <= 1'b1;
            armed  <= 1'b0;
        end else begin
            sck_p1 <= sck_s;
            csn_p1 <= csn_s;
            if (sync_ok && csn_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign lead_edge   = (sck_p1 == CPOL) && (sck_s != CPOL);
    assign trail_edge  = (sck_p1 != CPOL) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    // ---- frame FSM -------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A CSN rise wins over an SCK edge seen in the same cycle, so the final
    // trailing edge of a mode-0 frame that coincides with deselect does not
    // consume another word from the holding buffer.
    always_comb begin
        next_state = state;
        frame_end  = 1'b0;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        sample_en  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && csn_p1 && !csn_s) begin
                    next_state = ACTIVE;
                    load_en    = !CPHA;
                end
            end
            ACTIVE: begin
                if (csn_s && !csn_p1) begin
                    next_state = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    sample_en = sample_edge;
                    if (shift_edge) begin
                        if (bit_cnt == '0) begin
                            load_en = 1'b1;
                        end else begin
                            shift_en = 1'b1;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ---- datapath --------------------------------------------------------------
    // No bypass: a word accepted in a load cycle lands in the buffer while the
    // shift register takes the previous buffer contents (or FILL).
    assign accept = tx_valid && !buf_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (load_en) begin
                if (buf_full) begin
                    tx_shift <= buf_data;
                end else begin
                    tx_shift    <= FILL;
                    tx_underrun <= 1'b1;
                end
            end else if (shift_en) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (accept) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end else if (load_en) begin
                buf_full <= 1'b0;
            end

            if (frame_end) begin
                bit_cnt <= '0;
            end else if (sample_en) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], sdi_s};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    rx_data  <= {rx_shift[DATA_WIDTH-2:0], sdi_s};
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy       = (state == ACTIVE);
    assign spi_sdo_en = ~busy;
    assign spi_sdo_o  = tx_shift[DATA_WIDTH-1];
    assign tx_ready   = ~buf_full;

endmodule
